// File: rtl/ghr_checkpoint.sv
// ghr_checkpoint: global-history front end for a gshare predictor.
// Keeps the speculative history for PHT reads and checkpoints every predicted
// branch in an in-order queue. At resolution it produces the PHT update triple,
// and on a misprediction it repairs the speculative history from the checkpoint.
// Optional macro GHR_CHECKPOINT_PERF_CNT_EN adds resolve/mispredict counters.
module ghr_checkpoint #(
    parameter int HIST_W = 3,
    parameter int PC_W   = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    input  logic [PC_W-1:0]   pred_pc,
    input  logic              pred_taken,
    output logic              pred_ready,
    output logic [HIST_W-1:0] spec_history,
    input  logic              res_valid,
    input  logic              res_taken,
    input  logic              flush,
    output logic              upd_valid,
    output logic [PC_W-1:0]   upd_pc,
    output logic [HIST_W-1:0] upd_history,
    output logic              upd_taken,
    output logic              mispredict,
    output logic [HIST_W-1:0] commit_history,
    output logic              empty,
    output logic              res_err
`ifdef GHR_CHECKPOINT_PERF_CNT_EN
    ,
    output logic [31:0]       perf_branches,
    output logic [31:0]       perf_mispredicts
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // The newest outcome enters at the LSB; the oldest bit falls off the MSB.
    function automatic logic [HIST_W-1:0] shift_hist(input logic [HIST_W-1:0] h,
                                                     input logic b);
        return {h[HIST_W-2:0], b};
    endfunction

    // Checkpoint storage: one entry per in-flight predicted branch.
    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic [HIST_W-1:0] hist_q [DEPTH];
    logic              pred_q [DEPTH];

    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [CNT_W-1:0]  count;

    logic              full;
    logic              do_pop;
    logic              do_push;
    logic              mis_now;
    logic              err_now;
    logic [PC_W-1:0]   head_pc;
    logic [HIST_W-1:0] head_hist;
    logic              head_pred;

    // Decode this cycle's queue operations; flush beats everything, and a
    // misprediction kills any push because fetch is being redirected.
    always_comb begin
        full       = (count == FULL_COUNT);
        empty      = (count == '0);
        pred_ready = !full;
        head_pc    = pc_q[rptr];
        head_hist  = hist_q[rptr];
        head_pred  = pred_q[rptr];
        do_pop     = res_valid && !empty && !flush;
        mis_now    = do_pop && (res_taken != head_pred);
        do_push    = pred_valid && !full && !flush && !mis_now;
        err_now    = res_valid && empty && !flush;
    end

    // Write a checkpoint of the pre-shift history with each accepted push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                hist_q[i] <= '0;
                pred_q[i] <= 1'b0;
            end
        end else if (do_push) begin
            pc_q[wptr]   <= pred_pc;
            hist_q[wptr] <= spec_history;
            pred_q[wptr] <= pred_taken;
        end
    end

    // Pointer and occupancy bookkeeping, including wholesale clears on
    // flush and on a mispredicted resolve.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= rptr;
            count <= '0;
        end else if (mis_now) begin
            rptr  <= rptr + PTR_W'(1);
            wptr  <= rptr + PTR_W'(1);
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Speculative history: restored from the committed history on flush,
    // rebuilt from the checkpoint on a mispredict, otherwise advanced per push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spec_history <= '0;
        end else if (flush) begin
            spec_history <= commit_history;
        end else if (mis_now) begin
            spec_history <= shift_hist(head_hist, res_taken);
        end else if (do_push) begin
            spec_history <= shift_hist(spec_history, pred_taken);
        end
    end

    // Architectural history only ever sees resolved outcomes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_history <= '0;
        end else if (do_pop) begin
            commit_history <= shift_hist(commit_history, res_taken);
        end
    end

    // PHT update port: one-cycle strobes, data fields hold between updates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_valid   <= 1'b0;
            mispredict  <= 1'b0;
            upd_pc      <= '0;
            upd_history <= '0;
            upd_taken   <= 1'b0;
        end else begin
            upd_valid  <= do_pop;
            mispredict <= mis_now;
            if (do_pop) begin
                upd_pc      <= head_pc;
                upd_history <= head_hist;
                upd_taken   <= res_taken;
            end
        end
    end

    // A resolve with nothing in flight is a protocol error; remember it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_err <= 1'b0;
        end else if (err_now) begin
            res_err <= 1'b1;
        end
    end

`ifdef GHR_CHECKPOINT_PERF_CNT_EN
    // Free-running event counters; flush does not touch them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (do_pop) begin
                perf_branches <= perf_branches + 32'd1;
            end
            if (mis_now) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ghr_checkpoint.sv
// tb_ghr_checkpoint: directed vectors with hand-computed expectations for
// ghr_checkpoint (HIST_W=3, PC_W=16, DEPTH=4).
module tb_ghr_checkpoint;

    logic        clk;
    logic        rst;
    logic        pred_valid;
    logic [15:0] pred_pc;
    logic        pred_taken;
    logic        pred_ready;
    logic [2:0]  spec_history;
    logic        res_valid;
    logic        res_taken;
    logic        flush;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic [2:0]  upd_history;
    logic        upd_taken;
    logic        mispredict;
    logic [2:0]  commit_history;
    logic        empty;
    logic        res_err;
`ifdef GHR_CHECKPOINT_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    int totalChecks = 0;
    int passedChecks = 0;

    ghr_checkpoint #(.HIST_W(3), .PC_W(16), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_ready     (pred_ready),
        .spec_history   (spec_history),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .flush          (flush),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_history    (upd_history),
        .upd_taken      (upd_taken),
        .mispredict     (mispredict),
        .commit_history (commit_history),
        .empty          (empty),
        .res_err        (res_err)
`ifdef GHR_CHECKPOINT_PERF_CNT_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    // 10 time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual === expected) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, then return to idle.
    task automatic applyStimulus(input logic pv, input logic [15:0] pc, input logic pt,
                                 input logic rv, input logic rt, input logic fl);
        pred_valid = pv;
        pred_pc    = pc;
        pred_taken = pt;
        res_valid  = rv;
        res_taken  = rt;
        flush      = fl;
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        pred_valid = 1'b0;
        pred_pc    = '0;
        pred_taken = 1'b0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        flush      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_spec", 32'(spec_history), 32'd0);
        checkOutput("rst_commit", 32'(commit_history), 32'd0);
        checkOutput("rst_upd_valid", 32'(upd_valid), 32'd0);
        checkOutput("rst_mispredict", 32'(mispredict), 32'd0);
        checkOutput("rst_res_err", 32'(res_err), 32'd0);
        checkOutput("rst_ready", 32'(pred_ready), 32'd1);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        rst = 1'b1;

        // Two pushes advance the speculative history 000 -> 001 -> 010.
        applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("push1_spec", 32'(spec_history), 32'b001);
        checkOutput("push1_empty", 32'(empty), 32'd0);
        applyStimulus(1'b1, 16'h0044, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("push2_spec", 32'(spec_history), 32'b010);

        // Resolve both correctly, oldest first.
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("res1_valid", 32'(upd_valid), 32'd1);
        checkOutput("res1_pc", 32'(upd_pc), 32'h0040);
        checkOutput("res1_hist", 32'(upd_history), 32'b000);
        checkOutput("res1_taken", 32'(upd_taken), 32'd1);
        checkOutput("res1_mis", 32'(mispredict), 32'd0);
        checkOutput("res1_commit", 32'(commit_history), 32'b001);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("res2_pc", 32'(upd_pc), 32'h0044);
        checkOutput("res2_hist", 32'(upd_history), 32'b001);
        checkOutput("res2_taken", 32'(upd_taken), 32'd0);
        checkOutput("res2_commit", 32'(commit_history), 32'b010);
        checkOutput("res2_empty", 32'(empty), 32'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_upd_valid", 32'(upd_valid), 32'd0);
        checkOutput("idle_pc_hold", 32'(upd_pc), 32'h0044);

        // Mispredict: A (hist 010) and B (hist 101) pushed taken, A resolves not-taken.
        applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0104, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("mis_pre_spec", 32'(spec_history), 32'b011);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("mis_strobe", 32'(mispredict), 32'd1);
        checkOutput("mis_upd_pc", 32'(upd_pc), 32'h0100);
        checkOutput("mis_upd_hist", 32'(upd_history), 32'b010);
        checkOutput("mis_spec", 32'(spec_history), 32'b100);
        checkOutput("mis_commit", 32'(commit_history), 32'b100);
        checkOutput("mis_empty", 32'(empty), 32'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mis_strobe_drop", 32'(mispredict), 32'd0);
        checkOutput("mis_no_b_update", 32'(upd_valid), 32'd0);

        // Fill the queue: stored hists 100, 001, 010, 101; spec ends at 010.
        applyStimulus(1'b1, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0204, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0208, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("fill3_ready", 32'(pred_ready), 32'd1);
        applyStimulus(1'b1, 16'h020C, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("full_ready", 32'(pred_ready), 32'd0);
        checkOutput("full_spec", 32'(spec_history), 32'b010);
        applyStimulus(1'b1, 16'h0210, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("full_push_refused", 32'(spec_history), 32'b010);
        checkOutput("full_still_full", 32'(pred_ready), 32'd0);
        applyStimulus(1'b1, 16'h0214, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("full_pop_pc", 32'(upd_pc), 32'h0200);
        checkOutput("full_pop_hist", 32'(upd_history), 32'b100);
        checkOutput("full_pop_mis", 32'(mispredict), 32'd0);
        checkOutput("full_pop_spec", 32'(spec_history), 32'b010);
        checkOutput("full_pop_ready", 32'(pred_ready), 32'd1);
        checkOutput("full_pop_commit", 32'(commit_history), 32'b001);

        // Drain the remaining three; the refused 0x0214 must never appear.
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("drain1_pc", 32'(upd_pc), 32'h0204);
        checkOutput("drain1_hist", 32'(upd_history), 32'b001);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("drain2_pc", 32'(upd_pc), 32'h0208);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("drain3_pc", 32'(upd_pc), 32'h020C);
        checkOutput("drain3_hist", 32'(upd_history), 32'b101);
        checkOutput("drain3_commit", 32'(commit_history), 32'b010);
        checkOutput("drain3_empty", 32'(empty), 32'd1);

        // Flush with a coincident resolve: spec returns to commit (010).
        applyStimulus(1'b1, 16'h0300, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0304, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_pre_spec", 32'(spec_history), 32'b011);
        applyStimulus(1'b1, 16'h0308, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_empty", 32'(empty), 32'd1);
        checkOutput("flush_spec", 32'(spec_history), 32'b010);
        checkOutput("flush_no_upd", 32'(upd_valid), 32'd0);
        checkOutput("flush_no_mis", 32'(mispredict), 32'd0);
        checkOutput("flush_commit", 32'(commit_history), 32'b010);
        checkOutput("flush_no_err", 32'(res_err), 32'd0);

        // Resolve while empty sets the sticky error.
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("err_set", 32'(res_err), 32'd1);
        checkOutput("err_no_upd", 32'(upd_valid), 32'd0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("err_sticky", 32'(res_err), 32'd1);

        // Asynchronous reset mid-queue clears everything immediately.
        applyStimulus(1'b1, 16'h0400, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0404, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_empty", 32'(empty), 32'd1);
        checkOutput("arst_spec", 32'(spec_history), 32'd0);
        checkOutput("arst_err", 32'(res_err), 32'd0);
        checkOutput("arst_upd_pc", 32'(upd_pc), 32'd0);
        checkOutput("arst_upd_hist", 32'(upd_history), 32'd0);
        checkOutput("arst_ready", 32'(pred_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("arst_no_upd", 32'(upd_valid), 32'd0);
        checkOutput("arst_commit", 32'(commit_history), 32'd0);

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
